// File: rtl/conv_window_stream.sv
// conv_window_stream
//   Turns a raster-order, multi-channel pixel stream into one K_H x K_W x CH
//   window per output position, with zero padding and stride generated
//   internally. K_H-1 column-addressed line buffers hold the previous padded
//   rows, so each input pixel is read exactly once.
//
// Ports
//   clk_en      clock
//   rst_n       synchronous reset, active-low
//   start       1-cycle pulse that begins a frame (ignored unless idle)
//   pix_valid / pix_ready / pix_data   input pixel handshake, channel k at
//                                      [k*BITWIDTH +: BITWIDTH]
//   win_valid / win_ready / win_data   output window handshake, element (i,j,k)
//                                      at [((i*K_W+j)*CH+k)*BITWIDTH +: BITWIDTH]
//   win_row, win_col                   output position of the presented window
//   busy        high while scanning or finishing a frame
//   frame_done  1-cycle pulse once the last window has been accepted
module conv_window_stream #(
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8,
  parameter int K_W      = 3,
  parameter int K_H      = 3,
  parameter int STRIDE   = 1,
  parameter int PAD      = 0,
  parameter int BITWIDTH = 8,
  parameter int CH       = 1
) (
  input  logic                             clk_en,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             pix_valid,
  output logic                             pix_ready,
  input  logic [CH*BITWIDTH-1:0]           pix_data,
  output logic                             win_valid,
  input  logic                             win_ready,
  output logic [K_H*K_W*CH*BITWIDTH-1:0]   win_data,
  output logic [15:0]                      win_row,
  output logic [15:0]                      win_col,
  output logic                             busy,
  output logic                             frame_done
);

  localparam int DW = CH * BITWIDTH;
  localparam int WW = K_H * K_W * DW;
  localparam int PW = IMG_W + 2 * PAD;
  localparam int PH = IMG_H + 2 * PAD;
  localparam int AW = (PW > 1) ? $clog2(PW) : 1;

  localparam logic [15:0] COL_LAST  = 16'(PW - 1);
  localparam logic [15:0] ROW_END   = 16'(PH);
  localparam logic [15:0] COL_FIRST = 16'(K_W - 1);
  localparam logic [15:0] ROW_FIRST = 16'(K_H - 1);
  localparam logic [15:0] PAD_LO    = 16'(PAD);
  localparam logic [15:0] PAD_RIGHT = 16'(PAD + IMG_W);
  localparam logic [15:0] PAD_BOT   = 16'(PAD + IMG_H);
  localparam logic [15:0] S_LAST    = 16'(STRIDE - 1);
  localparam logic        COL_OK0   = (K_W == 1);
  localparam logic        ROW_OK0   = (K_H == 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t state_reg, state_next;

  logic [15:0] row_reg, col_reg;
  // Stride phase / output index trackers; *_ok means the window fits on that axis.
  logic [15:0] row_ph_reg, col_ph_reg, row_idx_reg, col_idx_reg;
  logic        row_ok_reg, col_ok_reg;

  logic          valid_reg;
  logic [WW-1:0] data_reg;
  logic [15:0]   out_row_reg, out_col_reg;

  logic          pad_pos, stall, scan_fin, adv, emit, last_col;
  logic [15:0]   col_next, row_next;
  logic [AW-1:0] col_addr;
  logic [DW-1:0] sample;

  assign stall    = valid_reg & ~win_ready;
  assign scan_fin = (row_reg == ROW_END);
  assign adv      = (state_reg == S_SCAN) & ~scan_fin & ~stall & (pad_pos | pix_valid);
  assign last_col = (col_reg == COL_LAST);
  assign col_next = last_col ? 16'd0 : col_reg + 16'd1;
  assign row_next = row_reg + 16'd1;
  assign col_addr = col_reg[AW-1:0];
  assign sample   = pad_pos ? '0 : pix_data;
  assign emit     = adv & row_ok_reg & col_ok_reg & (row_ph_reg == 16'd0) & (col_ph_reg == 16'd0);

  generate
    if (PAD > 0) begin : g_pad
      assign pad_pos = (row_reg < PAD_LO) | (row_reg >= PAD_BOT) |
                       (col_reg < PAD_LO) | (col_reg >= PAD_RIGHT);
    end else begin : g_nopad
      assign pad_pos = (row_reg >= PAD_BOT) | (col_reg >= PAD_RIGHT);
    end
  endgenerate

  // FSM: state register
  always_ff @(posedge clk_en) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // FSM: next state. The scan only finishes once the last window has left.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_SCAN;
      S_SCAN:  if (scan_fin && (!valid_reg || win_ready)) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy       = 1'b0;
    frame_done = 1'b0;
    pix_ready  = 1'b0;
    case (state_reg)
      S_SCAN: begin
        busy      = 1'b1;
        pix_ready = ~scan_fin & ~pad_pos & ~stall;
      end
      S_DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Scan position and stride phase. Each axis restarts its phase at the first
  // coordinate where a full kernel fits, so (pos - K + 1) % STRIDE is tracked
  // incrementally instead of divided out.
  always_ff @(posedge clk_en) begin
    if (!rst_n) begin
      row_reg     <= '0;
      col_reg     <= '0;
      row_ph_reg  <= '0;
      col_ph_reg  <= '0;
      row_idx_reg <= '0;
      col_idx_reg <= '0;
      row_ok_reg  <= 1'b0;
      col_ok_reg  <= 1'b0;
    end else if (state_reg == S_IDLE && start) begin
      row_reg     <= '0;
      col_reg     <= '0;
      row_ph_reg  <= '0;
      col_ph_reg  <= '0;
      row_idx_reg <= '0;
      col_idx_reg <= '0;
      row_ok_reg  <= ROW_OK0;
      col_ok_reg  <= COL_OK0;
    end else if (adv) begin
      col_reg <= col_next;
      if (col_next == COL_FIRST) begin
        col_ph_reg  <= '0;
        col_idx_reg <= '0;
        col_ok_reg  <= 1'b1;
      end else begin
        if (col_next == 16'd0) col_ok_reg <= 1'b0;
        if (col_ph_reg == S_LAST) begin
          col_ph_reg  <= '0;
          col_idx_reg <= col_idx_reg + 16'd1;
        end else begin
          col_ph_reg <= col_ph_reg + 16'd1;
        end
      end
      if (last_col) begin
        row_reg <= row_next;
        if (row_next == ROW_FIRST) begin
          row_ph_reg  <= '0;
          row_idx_reg <= '0;
          row_ok_reg  <= 1'b1;
        end else if (row_ph_reg == S_LAST) begin
          row_ph_reg  <= '0;
          row_idx_reg <= row_idx_reg + 16'd1;
        end else begin
          row_ph_reg <= row_ph_reg + 16'd1;
        end
      end
    end
  end

  // Line buffers. lb_tap[0] is the incoming sample; lb_tap[g+1] is what row
  // buffer g holds at the current column (g=0 is the most recent row). On each
  // advance a column shifts one buffer deeper, oldest row falling off the end.
  logic [DW-1:0] lb_tap [K_H];
  assign lb_tap[0] = sample;

  genvar gi, gj;
  generate
    for (gi = 0; gi < K_H - 1; gi++) begin : g_line
      logic [DW-1:0] mem [PW];
      always_ff @(posedge clk_en) begin
        if (adv) mem[col_addr] <= lb_tap[gi];
      end
      assign lb_tap[gi+1] = mem[col_addr];
    end
  endgenerate

  // Window register: columns shift left, new column (top row = oldest) enters on the right.
  logic [DW-1:0] win_reg   [K_H][K_W];
  logic [DW-1:0] win_shift [K_H][K_W];
  logic [WW-1:0] win_flat;

  generate
    for (gi = 0; gi < K_H; gi++) begin : g_wrow
      for (gj = 0; gj < K_W; gj++) begin : g_wcol
        if (gj == K_W - 1) begin : g_new
          assign win_shift[gi][gj] = lb_tap[K_H-1-gi];
        end else begin : g_old
          assign win_shift[gi][gj] = win_reg[gi][gj+1];
        end
        always_ff @(posedge clk_en) begin
          if (!rst_n)   win_reg[gi][gj] <= '0;
          else if (adv) win_reg[gi][gj] <= win_shift[gi][gj];
        end
        assign win_flat[(gi*K_W+gj)*DW +: DW] = win_shift[gi][gj];
      end
    end
  endgenerate

  // One-deep output register; reloads in the same cycle it is drained.
  always_ff @(posedge clk_en) begin
    if (!rst_n) begin
      valid_reg   <= 1'b0;
      data_reg    <= '0;
      out_row_reg <= '0;
      out_col_reg <= '0;
    end else if (emit) begin
      valid_reg   <= 1'b1;
      data_reg    <= win_flat;
      out_row_reg <= row_idx_reg;
      out_col_reg <= col_idx_reg;
    end else if (win_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign win_valid = valid_reg;
  assign win_data  = data_reg;
  assign win_row   = out_row_reg;
  assign win_col   = out_col_reg;

endmodule
